// File: rtl/comb_pkg.sv
// Shared defaults for the comb filter family (combfilter and inverse_comb).
package comb_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int DELAY_DEFAULT = 4;

  // Counter width able to hold the values 0..max_val.
  function automatic int count_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/comb_delay_line.sv
// DELAY-deep shift register of recovered samples; exposes only the oldest tap.
module comb_delay_line
  import comb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DELAY = DELAY_DEFAULT
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] oldest_o
);

  logic [WIDTH-1:0] taps_q [DELAY];

  // Tap 0 is the newest entry and tap DELAY-1 the oldest.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < DELAY; i++) taps_q[i] <= '0;
    end else if (shift_en_i) begin
      taps_q[0] <= data_i;
      for (int i = 1; i < DELAY; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign oldest_o = taps_q[DELAY-1];

endmodule

// File: rtl/inverse_comb.sv
// Inverse of a feedforward comb: x[n] = y[n] - x[n-DELAY] mod 2^WIDTH, 1-cycle latency.
// Optional INVERSE_COMB_PRIMED_EN adds primed_o, high once DELAY samples were accepted.
module inverse_comb
  import comb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DELAY = DELAY_DEFAULT
) (
  input  logic             CLK_i,
  input  logic             RST_N_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_o,
`ifdef INVERSE_COMB_PRIMED_EN
  output logic [WIDTH-1:0] data_out,
  output logic             primed_o
`else
  output logic [WIDTH-1:0] data_out
`endif
);

  logic [WIDTH-1:0] oldest;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Wrapping subtraction: no extra bits, no saturation.
  assign data_d = data_in - oldest;

  comb_delay_line #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_delay_line (
    .clk_i      (CLK_i),
    .clr_n_i    (RST_N_i),
    .shift_en_i (valid_i),
    .data_i     (data_d),
    .oldest_o   (oldest)
  );

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_d;
    end
  end

  assign data_out = data_q;
  assign valid_o  = valid_q;

`ifdef INVERSE_COMB_PRIMED_EN
  localparam int CW = count_width(DELAY);

  logic [CW-1:0] fill_q;
  logic          primed_q;

  // Counter saturates at DELAY; primed latches on the edge taking the DELAY-th sample.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (valid_i) begin
      if (fill_q != CW'(DELAY)) fill_q <= fill_q + CW'(1);
      if (fill_q == CW'(DELAY - 1)) primed_q <= 1'b1;
    end
  end

  assign primed_o = primed_q;
`endif

endmodule

// File: tb/tb_inverse_comb.sv
// Self-checking bench for inverse_comb (WIDTH=4, DELAY=4): directed cases plus a
// randomized round trip through a forward comb model.
module tb_inverse_comb;

  localparam int W = 4;
  localparam int D = 4;

  logic         CLK_i   = 1'b0;
  logic         RST_N_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         valid_o;
  logic [W-1:0] data_out;
`ifdef INVERSE_COMB_PRIMED_EN
  logic         primed_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK_i = ~CLK_i;

  inverse_comb #(
    .WIDTH (W),
    .DELAY (D)
  ) dut (
    .CLK_i    (CLK_i),
    .RST_N_i  (RST_N_i),
    .valid_i  (valid_i),
    .data_in  (data_in),
    .valid_o  (valid_o),
`ifdef INVERSE_COMB_PRIMED_EN
    .data_out (data_out),
    .primed_o (primed_o)
`else
    .data_out (data_out)
`endif
  );

  // Drives one cycle of input, then settles 1 time unit past the rising edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d);
    valid_i = v;
    data_in = d;
    @(posedge CLK_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expV, input logic [W-1:0] expD);
    checks++;
    assert (valid_o === expV) else begin
      errors++;
      $error("[TB] FAIL %s valid_o observed=%0b expected=%0b", tag, valid_o, expV);
    end
    checks++;
    assert (data_out === expD) else begin
      errors++;
      $error("[TB] FAIL %s data_out observed=%0d expected=%0d", tag, data_out, expD);
    end
  endtask

`ifdef INVERSE_COMB_PRIMED_EN
  task automatic checkPrimed(input string tag, input logic expP);
    checks++;
    assert (primed_o === expP) else begin
      errors++;
      $error("[TB] FAIL %s primed_o observed=%0b expected=%0b", tag, primed_o, expP);
    end
  endtask
`endif

  // Reset with a simultaneous valid sample, which must be dropped.
  task automatic resetDut(input string tag);
    RST_N_i = 1'b0;
    valid_i = 1'b1;
    data_in = 4'd7;
    @(posedge CLK_i);
    #1;
    checkOutput(tag, 1'b0, '0);
    RST_N_i = 1'b1;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] impulseExp [9];
    logic [W-1:0] xHist [$];
    logic [W-1:0] lastOut;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] expD;
    int           k;

    impulseExp = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd13, 4'd0, 4'd0, 4'd0, 4'd3};

    $display("[TB] reset state");
    resetDut("reset");

    $display("[TB] impulse, back-to-back");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, (i == 0) ? 4'd3 : 4'd0);
      checkOutput($sformatf("impulse[%0d]", i), 1'b1, impulseExp[i]);
    end
    applyStimulus(1'b0, 4'd9);
    checkOutput("idle_hold", 1'b0, 4'd3);

    $display("[TB] impulse with gaps");
    resetDut("reset_gaps");
    k = 0;
    lastOut = '0;
    for (int c = 0; k < 9; c++) begin
      if ((c % 4 == 0) || (c % 4 == 3)) begin
        applyStimulus(1'b1, (k == 0) ? 4'd3 : 4'd0);
        checkOutput($sformatf("gap_valid[%0d]", k), 1'b1, impulseExp[k]);
        lastOut = impulseExp[k];
        k++;
      end else begin
        applyStimulus(1'b0, 4'(c));
        checkOutput($sformatf("gap_idle[%0d]", c), 1'b0, lastOut);
      end
    end

    $display("[TB] wrap-around subtraction");
    resetDut("reset_wrap");
    applyStimulus(1'b1, 4'd1);
    checkOutput("wrap_seed", 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd0);
    checkOutput("wrap_0_minus_1", 1'b1, 4'd15);

    $display("[TB] reset mid-stream");
    resetDut("reset_pre");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)));
    resetDut("reset_mid");
    applyStimulus(1'b0, 4'd0);
    checkOutput("reset_mid_idle", 1'b0, 4'd0);
    xHist.delete();
    for (int i = 0; i < 8; i++) begin
      y = (i == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      expD = y - ((xHist.size() >= D) ? xHist[xHist.size() - D] : 4'd0);
      applyStimulus(1'b1, y);
      checkOutput($sformatf("post_reset[%0d]", i), 1'b1, expD);
      xHist.push_back(expD);
    end

    $display("[TB] random round trip");
    resetDut("reset_rt");
    xHist.delete();
    lastOut = '0;
    while (xHist.size() < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 4'($urandom_range(0, 15)));
        checkOutput("rt_idle", 1'b0, lastOut);
      end else begin
        x = 4'($urandom_range(0, 15));
        y = x + ((xHist.size() >= D) ? xHist[xHist.size() - D] : 4'd0);
        applyStimulus(1'b1, y);
        checkOutput($sformatf("rt[%0d]", xHist.size()), 1'b1, x);
        xHist.push_back(x);
        lastOut = x;
      end
    end

`ifdef INVERSE_COMB_PRIMED_EN
    $display("[TB] primed flag");
    resetDut("reset_primed");
    checkPrimed("primed_after_reset", 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)));
      applyStimulus(1'b0, 4'd0);
    end
    checkPrimed("primed_after_3", 1'b0);
    applyStimulus(1'b1, 4'd2);
    checkPrimed("primed_after_4", 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd1);
    checkPrimed("primed_stays", 1'b1);
    resetDut("reset_primed_clear");
    checkPrimed("primed_cleared", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inverse_comb.md
INVERSE_COMB -- requirements
Module: inverse_comb

Interface
REQ-001 Parameter WIDTH, default 4, sample width in bits; unsigned two's-complement modular data.
REQ-002 Parameter DELAY, default 4, comb delay D in accepted samples; legal range 1..16.
REQ-003 Port CLK_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port RST_N_i  input  1  reset, synchronous, active-low.
REQ-005 Port valid_i  input  1  data_in carries a new comb-filtered sample this cycle.
REQ-006 Port data_in  input  WIDTH  comb-encoded sample y[n].
REQ-007 Port valid_o  output  1  data_out carries a new recovered sample this cycle.
REQ-008 Port data_out  output  WIDTH  recovered sample x[n].

Function
REQ-009 The block SHALL invert the feedforward comb y[n] = x[n] + x[n-D] mod 2^WIDTH by computing x[n] = y[n] - x[n-D] mod 2^WIDTH.
REQ-010 The block SHALL keep a DELAY-deep delay line of past recovered outputs x[n-1]..x[n-D].
REQ-011 On a cycle with valid_i=1, the block SHALL compute x[n] from data_in and the oldest delay-line entry, and register it to data_out.
REQ-012 On that same edge, the block SHALL push x[n] into the delay line, discarding the oldest entry.
REQ-013 Latency SHALL be exactly 1 clock: valid_o is valid_i delayed by one cycle, and data_out updates on that edge.
REQ-014 With valid_i=0, the delay line and data_out SHALL hold, and valid_o SHALL be 0 the next cycle.
REQ-015 Subtraction SHALL wrap modulo 2^WIDTH with no saturation and no extra bits: 0 - 1 = 15 for WIDTH=4.
REQ-016 Back-to-back valid_i (every cycle) SHALL be sustained at full throughput without stalls.
REQ-017 The block SHALL apply no backpressure; every valid_i sample is consumed.

Reset
REQ-018 While RST_N_i=0 at a rising edge, all delay-line entries SHALL clear to 0, data_out SHALL be 0, and valid_o SHALL be 0.
REQ-019 Reset SHALL take priority over a simultaneous valid_i=1; that sample is dropped.
REQ-020 After reset releases, the first accepted sample SHALL see x[n-D]=0, so data_out equals data_in.
REQ-021 Reset asserted mid-stream SHALL discard all history; no pre-reset value may influence a later output.

Configuration
REQ-022 Macro INVERSE_COMB_PRIMED_EN defined: the block SHALL add output port primed_o (1 bit) and a saturating fill counter, cleared by reset.
REQ-023 With the macro, primed_o SHALL assert on the edge that accepts the DELAY-th sample after reset, and stay high until the next reset.
REQ-024 Macro undefined: the block SHALL have no primed_o port and no fill counter; all other behaviour is identical.

Structure
REQ-025 A shared package comb_pkg SHALL hold the WIDTH default (4) and the DELAY default (4), also used by combfilter.
REQ-026 The delay line SHALL be a sub-module comb_delay_line (parameters WIDTH and DELAY; ports: shift enable, data in, oldest-tap out) with a synchronous active-low clear.

Verification (DELAY=4, WIDTH=4)
REQ-027 Impulse: reset, then data_in = 3,0,0,0,0,0,0,0,0 every cycle -> data_out = 3,0,0,0,13,0,0,0,3.
REQ-028 Round trip: random x through a forward comb model into data_in -> data_out == x for 200 samples.
REQ-029 Gaps: valid_i toggled 1,0,0,1 with the same impulse stream -> outputs match the gap-free stream in order; valid_o only one cycle after each valid_i.
REQ-030 Wrap: history x[n-4]=1, data_in=0 -> data_out=15.
REQ-031 Reset mid-stream after 6 samples, then data_in=5 -> data_out=5, valid_o=1 one cycle later.
REQ-032 With INVERSE_COMB_PRIMED_EN: primed_o=0 after 3 accepted samples and 1 after the 4th; reset clears it.
